// File: rtl/eth_helper_pkg.sv
// eth_helper_pkg: frame layout constants and parser state type shared by the framer and parser.
package eth_helper_pkg;
    localparam int BEAT_W = 3;
    localparam logic [BEAT_W-1:0] BEAT_HDR0 = 3'd0;
    localparam logic [BEAT_W-1:0] BEAT_HDR1 = 3'd1;
    localparam logic [BEAT_W-1:0] PAYLOAD_BEAT = 3'd4;
    localparam logic [BEAT_W-1:0] BEAT_TRAILER = 3'd7;
    localparam logic [23:0] TRAILER_WORD = 24'h001337;
    localparam logic [7:0] TRAILER_KEEP = 8'h07;
    localparam logic [47:0] BROADCAST_ADDR = 48'hFFFF_FFFF_FFFF;
    typedef enum logic [2:0] {IDLE, HDR, BODY, TRAILER, DRAIN} parser_state_t;
endpackage

// File: rtl/eth_payload_out_reg.sv
// eth_payload_out_reg: single-entry AXIS output register; s_ready is the registered inverse of the next valid.
module eth_payload_out_reg #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    load,
    input  logic [DATA_WIDTH-1:0]   load_data,
    output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                    M_AXIS_tvalid,
    output logic                    M_AXIS_tlast,
    input  logic                    M_AXIS_tready,
    output logic                    s_ready
);
    logic valid_n;

    always_comb valid_n = load || (M_AXIS_tvalid && !M_AXIS_tready);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            M_AXIS_tdata  <= '0;
            M_AXIS_tkeep  <= '0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
            s_ready       <= 1'b0;
        end else begin
            M_AXIS_tvalid <= valid_n;
            M_AXIS_tlast  <= valid_n;
            M_AXIS_tkeep  <= {(DATA_WIDTH/8){valid_n}};
            s_ready       <= !valid_n;
            if (load) M_AXIS_tdata <= load_data;
        end
    end
endmodule

// File: rtl/eth_single_packet_parser.sv
// eth_single_packet_parser: checks fixed-layout 8-beat frames and emits the single payload beat of each good one.
// Only DATA_WIDTH=64 and FRAME_BEATS=8 are supported.
module eth_single_packet_parser #(
    parameter int          DATA_WIDTH    = 64,
    parameter int          FRAME_BEATS   = 8,
    parameter logic [2:0]  PAYLOAD_BEAT  = eth_helper_pkg::PAYLOAD_BEAT,
    parameter logic [23:0] TRAILER_WORD  = eth_helper_pkg::TRAILER_WORD,
    parameter bit          CHECK_PADDING = 1'b0,
    parameter int          CNT_WIDTH     = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
    input  logic                    S_AXIS_tvalid,
    input  logic                    S_AXIS_tlast,
    output logic                    S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                    M_AXIS_tvalid,
    output logic                    M_AXIS_tlast,
    input  logic                    M_AXIS_tready,
    input  logic [47:0]             Local_Addr,
    input  logic                    Accept_Broadcast,
    input  logic [15:0]             Link_Type,
    input  logic [15:0]             SyncWord,
    output logic [47:0]             Rx_Source_Addr,
    output logic [CNT_WIDTH-1:0]    Frames_Ok,
    output logic [CNT_WIDTH-1:0]    Frames_Dropped,
    output logic                    Frame_Error
);
    import eth_helper_pkg::*;

    localparam logic [2:0] LAST_BEAT   = 3'(FRAME_BEATS - 1);
    localparam logic [2:0] PRE_TRAILER = 3'(FRAME_BEATS - 2);

    parser_state_t state_q, state_n;
    logic [2:0] cnt_q, cnt_n;
    logic bad_q, beat_bad, frame_bad, dst_ok, is_pad, acc, good, drop, ferr;
    logic [47:0] src_q;
    logic [DATA_WIDTH-1:0] payload_q;

    always_comb begin
        acc = S_AXIS_tvalid && S_AXIS_tready;
        dst_ok = S_AXIS_tdata[47:0] == Local_Addr || (Accept_Broadcast && S_AXIS_tdata[47:0] == BROADCAST_ADDR);
        is_pad = cnt_q > BEAT_HDR1 && cnt_q < LAST_BEAT && cnt_q != PAYLOAD_BEAT;
        beat_bad = state_q != DRAIN && (
            S_AXIS_tkeep != (state_q == TRAILER ? TRAILER_KEEP : 8'hFF) ||
            (state_q == IDLE && !dst_ok) ||
            (state_q == HDR && (S_AXIS_tdata[63:48] != SyncWord || S_AXIS_tdata[47:32] != Link_Type)) ||
            (state_q == BODY && CHECK_PADDING && is_pad && S_AXIS_tdata != '0) ||
            (state_q == TRAILER && S_AXIS_tdata[23:0] != TRAILER_WORD));
        frame_bad = bad_q || beat_bad;
        good = acc && S_AXIS_tlast && state_q == TRAILER && !frame_bad;
        drop = acc && S_AXIS_tlast && !good;
        ferr = acc && S_AXIS_tlast && state_q != TRAILER;
        cnt_n = !acc ? cnt_q : (S_AXIS_tlast || state_q == TRAILER || state_q == DRAIN) ? 3'd0 : cnt_q + 1'b1;
        state_n = state_q;
        if (acc) begin
            if (S_AXIS_tlast) state_n = IDLE;
            else if (state_q == TRAILER || state_q == DRAIN) state_n = DRAIN;
            else if (cnt_q == BEAT_HDR0) state_n = HDR;
            else if (cnt_q == PRE_TRAILER) state_n = TRAILER;
            else state_n = BODY;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Bad flag is sticky within a frame and cleared by whatever beat ends it.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            bad_q          <= 1'b0;
            src_q          <= '0;
            payload_q      <= '0;
            Rx_Source_Addr <= '0;
            Frames_Ok      <= '0;
            Frames_Dropped <= '0;
            Frame_Error    <= 1'b0;
        end else begin
            Frame_Error <= ferr;
            if (acc) bad_q <= S_AXIS_tlast ? 1'b0 : frame_bad;
            if (acc && state_q == IDLE) src_q[15:0] <= S_AXIS_tdata[63:48];
            if (acc && state_q == HDR) src_q[47:16] <= S_AXIS_tdata[31:0];
            if (acc && state_q == BODY && cnt_q == PAYLOAD_BEAT) payload_q <= S_AXIS_tdata;
            if (good) begin
                Rx_Source_Addr <= src_q;
                Frames_Ok      <= Frames_Ok + 1'b1;
            end
            if (drop) Frames_Dropped <= Frames_Dropped + 1'b1;
        end
    end

    eth_payload_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .load          (good),
        .load_data     (payload_q),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tkeep  (M_AXIS_tkeep),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .M_AXIS_tready (M_AXIS_tready),
        .s_ready       (S_AXIS_tready)
    );
endmodule

// File: tb/tb_eth_single_packet_parser.sv
// tb_eth_single_packet_parser: directed frames against hand-computed outputs and counters.
module tb_eth_single_packet_parser;
    localparam logic [47:0] LOCAL = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] SRC   = 48'h112233445566;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [15:0] SYNC  = 16'hA5A5;
    localparam logic [15:0] LTYPE = 16'h0800;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [63:0] S_AXIS_tdata = '0;
    logic [7:0]  S_AXIS_tkeep = '0;
    logic        S_AXIS_tvalid = 1'b0;
    logic        S_AXIS_tlast = 1'b0;
    logic        S_AXIS_tready;
    logic [63:0] M_AXIS_tdata;
    logic [7:0]  M_AXIS_tkeep;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tlast;
    logic        M_AXIS_tready = 1'b1;
    logic        Accept_Broadcast = 1'b0;
    logic [47:0] Rx_Source_Addr;
    logic [15:0] Frames_Ok;
    logic [15:0] Frames_Dropped;
    logic        Frame_Error;

    int checks = 0;
    int failures = 0;
    int out_cnt = 0;
    int ferr_cnt = 0;
    logic [63:0] out_data = '0;

    eth_single_packet_parser dut (
        .ACLK             (ACLK),
        .ARESETN          (ARESETN),
        .S_AXIS_tdata     (S_AXIS_tdata),
        .S_AXIS_tkeep     (S_AXIS_tkeep),
        .S_AXIS_tvalid    (S_AXIS_tvalid),
        .S_AXIS_tlast     (S_AXIS_tlast),
        .S_AXIS_tready    (S_AXIS_tready),
        .M_AXIS_tdata     (M_AXIS_tdata),
        .M_AXIS_tkeep     (M_AXIS_tkeep),
        .M_AXIS_tvalid    (M_AXIS_tvalid),
        .M_AXIS_tlast     (M_AXIS_tlast),
        .M_AXIS_tready    (M_AXIS_tready),
        .Local_Addr       (LOCAL),
        .Accept_Broadcast (Accept_Broadcast),
        .Link_Type        (LTYPE),
        .SyncWord         (SYNC),
        .Rx_Source_Addr   (Rx_Source_Addr),
        .Frames_Ok        (Frames_Ok),
        .Frames_Dropped   (Frames_Dropped),
        .Frame_Error      (Frame_Error)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (M_AXIS_tvalid && M_AXIS_tready) begin
            out_cnt  <= out_cnt + 1;
            out_data <= M_AXIS_tdata;
        end
        if (Frame_Error) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n = 0;
        S_AXIS_tdata = d;
        S_AXIS_tkeep = k;
        S_AXIS_tlast = l;
        S_AXIS_tvalid = 1'b1;
        while (!S_AXIS_tready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (n == 50) check("s_ready_timeout", S_AXIS_tready, 1);
        @(negedge ACLK);
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] sync, input logic [63:0] pay,
                              input int last_at, input int stop);
        logic [63:0] d;
        for (int i = 0; i < stop; i++) begin
            d = i == 0 ? {SRC[15:0], dst} : i == 1 ? {sync, LTYPE, SRC[47:16]} :
                i == 4 ? pay : i == 7 ? {40'h0, 24'h001337} : 64'h0;
            send_beat(d, i == 7 ? 8'h07 : 8'hFF, i == last_at);
            if (i == last_at) break;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge ACLK);
    endtask

    initial begin
        idle(3);
        check("rst_s_ready", S_AXIS_tready, 0);
        check("rst_m_valid", M_AXIS_tvalid, 0);
        check("rst_m_last", M_AXIS_tlast, 0);
        check("rst_m_keep", M_AXIS_tkeep, 0);
        check("rst_m_data", M_AXIS_tdata, 0);
        check("rst_ok", Frames_Ok, 0);
        check("rst_drop", Frames_Dropped, 0);
        check("rst_src", Rx_Source_Addr, 0);
        check("rst_ferr", Frame_Error, 0);
        ARESETN = 1'b1;
        idle(1);
        check("s_ready_rise", S_AXIS_tready, 1);

        send_frame(LOCAL, SYNC, 64'hDEADBEEF_CAFEF00D, 7, 8);
        check("good_valid", M_AXIS_tvalid, 1);
        check("good_keep", M_AXIS_tkeep, 8'hFF);
        check("good_last", M_AXIS_tlast, 1);
        check("good_data", M_AXIS_tdata, 64'hDEADBEEF_CAFEF00D);
        check("good_s_ready", S_AXIS_tready, 0);
        idle(3);
        check("good_out_cnt", out_cnt, 1);
        check("good_out_data", out_data, 64'hDEADBEEF_CAFEF00D);
        check("good_ok", Frames_Ok, 1);
        check("good_src", Rx_Source_Addr, SRC);

        send_frame(BCAST, SYNC, 64'h1111, 7, 8);
        idle(3);
        check("bc_off_drop", Frames_Dropped, 1);
        check("bc_off_out", out_cnt, 1);
        Accept_Broadcast = 1'b1;
        send_frame(BCAST, SYNC, 64'h2222, 7, 8);
        idle(3);
        check("bc_on_ok", Frames_Ok, 2);
        check("bc_on_out", out_data, 64'h2222);
        Accept_Broadcast = 1'b0;

        send_frame(LOCAL, 16'h1234, 64'h3333, 7, 8);
        idle(3);
        check("sync_drop", Frames_Dropped, 2);
        check("sync_out", out_cnt, 2);
        check("sync_ferr", ferr_cnt, 0);

        send_frame(LOCAL, SYNC, 64'h4444, 3, 8);
        idle(3);
        check("early_ferr", ferr_cnt, 1);
        check("early_drop", Frames_Dropped, 3);
        send_frame(LOCAL, SYNC, 64'h01234567_89ABCDEF, 7, 8);
        idle(3);
        check("after_early_out", out_data, 64'h01234567_89ABCDEF);
        check("after_early_ok", Frames_Ok, 3);

        M_AXIS_tready = 1'b0;
        send_frame(LOCAL, SYNC, 64'h5555_AAAA, 7, 8);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", M_AXIS_tvalid, 1);
            check("bp_data", M_AXIS_tdata, 64'h5555_AAAA);
            check("bp_s_ready", S_AXIS_tready, 0);
            idle(1);
        end
        M_AXIS_tready = 1'b1;
        idle(1);
        check("bp_rel_valid", M_AXIS_tvalid, 0);
        check("bp_rel_last", M_AXIS_tlast, 0);
        check("bp_rel_keep", M_AXIS_tkeep, 0);
        check("bp_rel_s_ready", S_AXIS_tready, 1);
        check("bp_out_cnt", out_cnt, 4);

        send_frame(LOCAL, SYNC, 64'h6666, 9, 10);
        idle(3);
        check("drain_drop", Frames_Dropped, 4);
        check("drain_ferr", ferr_cnt, 2);
        check("drain_out", out_cnt, 4);

        send_frame(LOCAL, SYNC, 64'h7777, 7, 5);
        ARESETN = 1'b0;
        idle(2);
        check("mid_rst_ok", Frames_Ok, 0);
        check("mid_rst_drop", Frames_Dropped, 0);
        check("mid_rst_valid", M_AXIS_tvalid, 0);
        ARESETN = 1'b1;
        send_frame(LOCAL, SYNC, 64'h8888_9999, 7, 8);
        idle(3);
        check("post_rst_ok", Frames_Ok, 1);
        check("post_rst_drop", Frames_Dropped, 0);
        check("post_rst_out", out_data, 64'h8888_9999);
        check("post_rst_cnt", out_cnt, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
